// File: rtl/i2c_reg_reader_pkg.sv
// Shared types and constants for the i2c register-read sequencer.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    OUTPUT,
    FINISH,
    FAIL
  } state_t;

  localparam logic [3:0]  I2C_STATUS_OK = 4'h0;
  localparam int unsigned TIMEOUT_DEF   = 4095;
  localparam int unsigned TO_W          = $clog2(TIMEOUT_DEF + 1);

endpackage

// File: rtl/i2c_reg_reader_if.sv
// Read-port bus between the register reader and i2c_master.
interface i2c_reg_reader_if #(
  parameter int unsigned DATA_W = 16
);
  logic [6:0]        m_chip_addr;
  logic [7:0]        m_reg_addr;
  logic              m_read_en;
  logic              m_busy;
  logic              m_done;
  logic [3:0]        m_status;
  logic [DATA_W-1:0] m_data;

  modport master (
    output m_chip_addr, m_reg_addr, m_read_en,
    input  m_busy, m_done, m_status, m_data
  );

  modport slave (
    input  m_chip_addr, m_reg_addr, m_read_en,
    output m_busy, m_done, m_status, m_data
  );
endinterface

// File: rtl/i2c_reg_reader_timeout.sv
// Per-attempt watchdog: loadable down-counter, expire once it has run out after a load.
module i2c_reader_timeout #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  logic         armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = armed && (cnt == '0);
endmodule

// File: rtl/i2c_reg_reader.sv
// Reads COUNT consecutive registers via i2c_master and streams them out with valid/ready.
module i2c_reg_reader
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RETRIES = 2,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        chip_addr,
  input  logic [7:0]        base_reg,
  input  logic [8:0]        count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        err_reg,
  i2c_reg_reader_if.master  bus,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [7:0]        rd_reg,
  output logic [DATA_W-1:0] rd_data
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned ATT_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  state_t           state;
  logic [8:0]       remaining;
  logic [7:0]       cur_reg;
  logic [ATT_W-1:0] attempts;
  logic             abort_pend;

  logic to_expire;
  logic attempt_failed;
  logic retry_ok;
  logic stop_req;

  i2c_reader_timeout #(
    .W (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ISSUE),
    .clear    (state == IDLE),
    .en       (state == WAIT_BUSY || state == WAIT_DONE),
    .load_val (CNT_W'(TIMEOUT)),
    .expire   (to_expire)
  );

  // A NACK and a timeout are the same kind of failed attempt for the retry rule.
  always_comb begin
    attempt_failed = 1'b0;
    if (state == WAIT_BUSY)
      attempt_failed = to_expire;
    else if (state == WAIT_DONE)
      attempt_failed = bus.m_done ? (bus.m_status != I2C_STATUS_OK) : to_expire;
    retry_ok = 32'(attempts) < RETRIES;
    stop_req = abort_pend || abort;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      remaining       <= '0;
      cur_reg         <= '0;
      attempts        <= '0;
      abort_pend      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_reg         <= '0;
      bus.m_chip_addr <= '0;
      bus.m_reg_addr  <= '0;
      bus.m_read_en   <= 1'b0;
      rd_valid        <= 1'b0;
      rd_reg          <= '0;
      rd_data         <= '0;
    end else begin
      bus.m_read_en <= 1'b0;
      done          <= 1'b0;
      // abort may arrive while a master transaction is in flight; hold it for the next safe point
      if (abort && state != IDLE) abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            error      <= 1'b0;
            abort_pend <= 1'b0;
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              bus.m_chip_addr <= chip_addr;
              bus.m_reg_addr  <= base_reg;
              cur_reg         <= base_reg;
              remaining       <= count;
              attempts        <= '0;
              busy            <= 1'b1;
              state           <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (stop_req) begin
            state <= FINISH;
          end else begin
            bus.m_read_en <= 1'b1;
            state         <= WAIT_BUSY;
          end
        end

        WAIT_BUSY, WAIT_DONE: begin
          if (attempt_failed) begin
            if (retry_ok) begin
              attempts <= attempts + 1'b1;
              state    <= ISSUE;
            end else begin
              state <= FAIL;
            end
          end else if (state == WAIT_BUSY) begin
            if (bus.m_busy) state <= WAIT_DONE;
          end else if (bus.m_done) begin
            rd_reg   <= cur_reg;
            rd_data  <= bus.m_data;
            rd_valid <= 1'b1;
            state    <= OUTPUT;
          end
        end

        OUTPUT: begin
          if (stop_req) begin
            rd_valid <= 1'b0;
            state    <= FINISH;
          end else if (rd_ready) begin
            rd_valid       <= 1'b0;
            remaining      <= remaining - 1'b1;
            cur_reg        <= cur_reg + 1'b1;
            bus.m_reg_addr <= cur_reg + 1'b1;
            attempts       <= '0;
            state          <= (remaining > 9'd1) ? ISSUE : FINISH;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        FAIL: begin
          error   <= 1'b1;
          err_reg <= cur_reg;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
